// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte port into a small FIFO,
// serialized LSB-first with back-to-back frames at 2*CLK_PER_HALF_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 86,
    parameter int DEPTH            = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
    localparam int AW         = $clog2(DEPTH);
    localparam int BW         = $clog2(BIT_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [BW-1:0]   baud, baud_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;
    logic            txd_q, txd_n;
    logic            push, pop, has_data, bit_end;

    // in_ready looks only at the registered count, so a full FIFO stays
    // closed on the edge that pops it.
    assign in_ready   = (count != FULL);
    assign push       = in_valid && in_ready;
    assign has_data   = (count != '0);
    assign bit_end    = (baud == BAUD_LAST);
    assign fifo_count = count;
    assign busy       = (state != IDLE) || has_data;
    assign txd        = txd_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd_q   <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd_q   <= txd_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        baud_n  = (state == IDLE || bit_end) ? '0 : baud + BW'(1);
        case (state)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = shift >> 1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (bit_end) begin
                    if (has_data) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // txd is registered from the next-state view so the line changes on the
        // same edge as the state transition.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end
endmodule
